// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the data-memory access controller
package dmem_pkg;

    localparam logic [2:0] ACC_WORD = 3'b000;
    localparam logic [2:0] ACC_BYTE = 3'b001;
    localparam logic [2:0] ACC_HALF = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_store_lane_align.sv
// rtl/dmem_store_lane_align.sv - store byte-enable and lane replication
module store_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  acc_i,
    input  logic [31:0] data_i,
    output logic [3:0]  we_o,
    output logic [31:0] wdata_o
);

    // Encoding 11 falls through to the word default.
    always_comb begin
        we_o    = 4'b1111;
        wdata_o = data_i;
        if (acc_i == ACC_BYTE[1:0]) begin
            we_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{data_i[7:0]}};
        end else if (acc_i == ACC_HALF[1:0]) begin
            we_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{data_i[15:0]}};
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - M-stage load/store controller for the data BRAM
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReq,
    input  logic              MemWrite,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       WriteData,
    input  logic [2:0]        ByteAccess,
    output logic              Stall,
    output logic              Misaligned,
    output logic              Bram_en,
    output logic [3:0]        Bram_we,
    output logic [ADDR_W-1:0] Bram_addr,
    output logic [31:0]       Bram_wdata,
    input  logic [31:0]       Bram_rdata,
    output logic              RspValid,
    output logic [31:0]       ReadData_b,
    output logic [1:0]        RspAddrLo,
    output logic [2:0]        RspByteAccess
);

    localparam logic [1:0] WAIT_LAST = 2'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    dmem_state_t       state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [2:0]        bacc_q, bacc_d;
    logic [31:0]       hold_q, hold_d;

    logic [ADDR_W-1:0] req_addr;
    logic              is_byte, is_half, misaligned_req;
    logic [3:0]        lane_we;
    logic [31:0]       lane_wdata;
    logic              unused_hi;

    // Upper address bits are dropped so accesses wrap modulo the BRAM size.
    assign req_addr  = ALUResult[ADDR_W+1:2];
    assign unused_hi = ^ALUResult[31:ADDR_W+2];

    assign is_byte        = (ByteAccess[1:0] == ACC_BYTE[1:0]);
    assign is_half        = (ByteAccess[1:0] == ACC_HALF[1:0]);
    assign misaligned_req = is_half ? ALUResult[0]
                                    : (!is_byte && (ALUResult[1:0] != 2'b00));

    assign RspAddrLo     = addr_lo_q;
    assign RspByteAccess = bacc_q;

    store_lane_align u_align (
        .addr_lo_i (ALUResult[1:0]),
        .acc_i     (ByteAccess[1:0]),
        .data_i    (WriteData),
        .we_o      (lane_we),
        .wdata_o   (lane_wdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        addr_lo_d  = addr_lo_q;
        bacc_d     = bacc_q;
        hold_d     = hold_q;
        Stall      = 1'b0;
        Misaligned = 1'b0;
        Bram_en    = 1'b0;
        Bram_we    = 4'b0000;
        Bram_addr  = '0;
        Bram_wdata = '0;
        RspValid   = 1'b0;
        ReadData_b = hold_q;
        case (state_q)
            IDLE: begin
                if (MemReq && !reset) begin
                    if (misaligned_req) begin
                        Misaligned = 1'b1;
                    end else if (MemWrite) begin
                        Bram_en    = 1'b1;
                        Bram_we    = lane_we;
                        Bram_addr  = req_addr;
                        Bram_wdata = lane_wdata;
                    end else begin
                        Bram_en   = 1'b1;
                        Bram_addr = req_addr;
                        Stall     = 1'b1;
                        addr_d    = req_addr;
                        addr_lo_d = ALUResult[1:0];
                        bacc_d    = ByteAccess;
                        cnt_d     = '0;
                        state_d   = (RD_LAT > 1) ? WAIT : DONE;
                    end
                end
            end
            WAIT: begin
                Stall     = 1'b1;
                Bram_en   = 1'b1;
                Bram_addr = addr_q;
                cnt_d     = cnt_q + 2'd1;
                if (cnt_q == WAIT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The BRAM port stays idle here: the instruction leaves M this cycle.
                RspValid   = 1'b1;
                ReadData_b = Bram_rdata;
                hold_d     = Bram_rdata;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            addr_lo_q <= '0;
            bacc_q    <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            addr_lo_q <= addr_lo_d;
            bacc_q    <= bacc_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - bench for dmem_access_ctrl at read latencies 1, 2 and 3
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic        mem_req         [3];
    logic        mem_write       [3];
    logic [31:0] alu_result      [3];
    logic [31:0] write_data      [3];
    logic [2:0]  byte_access     [3];
    logic        stall           [3];
    logic        misaligned      [3];
    logic        bram_en         [3];
    logic [3:0]  bram_we         [3];
    logic [9:0]  bram_addr       [3];
    logic [31:0] bram_wdata      [3];
    logic        rsp_valid       [3];
    logic [31:0] read_data_b     [3];
    logic [1:0]  rsp_addr_lo     [3];
    logic [2:0]  rsp_byte_access [3];

    logic [31:0] ref_mem   [3][1024];
    logic [31:0] last_load [3];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] mem  [1024];
        logic [31:0] pipe [4];

        dmem_access_ctrl #(.ADDR_W(10), .RD_LAT(g + 1)) u_dut (
            .clk           (clk),
            .reset         (reset),
            .MemReq        (mem_req[g]),
            .MemWrite      (mem_write[g]),
            .ALUResult     (alu_result[g]),
            .WriteData     (write_data[g]),
            .ByteAccess    (byte_access[g]),
            .Stall         (stall[g]),
            .Misaligned    (misaligned[g]),
            .Bram_en       (bram_en[g]),
            .Bram_we       (bram_we[g]),
            .Bram_addr     (bram_addr[g]),
            .Bram_wdata    (bram_wdata[g]),
            .Bram_rdata    (pipe[g]),
            .RspValid      (rsp_valid[g]),
            .ReadData_b    (read_data_b[g]),
            .RspAddrLo     (rsp_addr_lo[g]),
            .RspByteAccess (rsp_byte_access[g])
        );

        // Read-first BRAM whose output arrives g+1 clocks after the enabled edge.
        always @(posedge clk) begin
            if (bram_en[g]) begin
                for (int b = 0; b < 4; b++)
                    if (bram_we[g][b]) mem[bram_addr[g]][8*b +: 8] <= bram_wdata[g][8*b +: 8];
                pipe[0] <= mem[bram_addr[g]];
            end
            for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
        end
    end

    task automatic run_access(input int d, input bit st, input logic [2:0] acc,
                              input logic [31:0] addr, input logic [31:0] data);
        int sz, wi, lane;
        bit mis;
        logic [3:0]   ewe;
        logic [31:0]  ewd, eword;
        logic [127:0] obs, exp;
        sz  = (acc[1:0] == 2'd1) ? 1 : (acc[1:0] == 2'd2) ? 2 : 4;
        mis = (int'(addr[1:0]) % sz) != 0;
        wi  = int'(addr[11:2]);
        @(negedge clk);
        mem_req[d] = 1'b1; mem_write[d] = st; alu_result[d] = addr;
        write_data[d] = data; byte_access[d] = acc;
        #1;
        if (mis) begin
            obs = {stall[d], misaligned[d], bram_en[d], bram_we[d], rsp_valid[d], read_data_b[d]};
            exp = {1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, last_load[d]};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL misaligned d%0d addr=%h acc=%0d got %h want %h", d, addr, acc, obs, exp);
            end
        end else if (st) begin
            ewe = '0;
            for (int b = 0; b < sz; b++) ewe[(int'(addr[1:0]) + b) % 4] = 1'b1;
            for (int l = 0; l < 4; l++) ewd[8*l +: 8] = data[8*(l % sz) +: 8];
            obs = {stall[d], misaligned[d], bram_en[d], bram_we[d], rsp_valid[d],
                   bram_addr[d], bram_wdata[d], read_data_b[d]};
            exp = {1'b0, 1'b0, 1'b1, ewe, 1'b0, wi[9:0], ewd, last_load[d]};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL store d%0d addr=%h acc=%0d got %h want %h", d, addr, acc, obs, exp);
            end
            for (int b = 0; b < sz; b++) begin
                lane = (int'(addr[1:0]) + b) % 4;
                ref_mem[d][wi][8*lane +: 8] = data[8*b +: 8];
            end
        end else begin
            exp = {1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, wi[9:0], last_load[d]};
            for (int k = 0; k < d + 1; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    #1;
                end
                obs = {stall[d], misaligned[d], bram_en[d], bram_we[d], rsp_valid[d],
                       bram_addr[d], read_data_b[d]};
                n_cmp++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL load_stall d%0d addr=%h cyc%0d got %h want %h", d, addr, k, obs, exp);
                end
            end
            eword = ref_mem[d][wi];
            @(negedge clk);
            #1;
            obs = {stall[d], misaligned[d], bram_en[d], bram_we[d], rsp_valid[d],
                   read_data_b[d], rsp_addr_lo[d], rsp_byte_access[d]};
            exp = {1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, eword, addr[1:0], acc};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL load_done d%0d addr=%h got %h want %h", d, addr, obs, exp);
            end
            last_load[d] = eword;
        end
    endtask

    task automatic idle();
        logic [63:0] obs, exp;
        @(negedge clk);
        for (int d = 0; d < 3; d++) mem_req[d] = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            obs = {stall[d], misaligned[d], bram_en[d], bram_we[d], rsp_valid[d], read_data_b[d]};
            exp = {1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, last_load[d]};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL idle d%0d got %h want %h", d, obs, exp);
            end
        end
    endtask

    task automatic check_all_zero(input int d, input string tag);
        logic [127:0] obs;
        obs = {stall[d], misaligned[d], bram_en[d], bram_we[d], bram_addr[d], bram_wdata[d],
               rsp_valid[d], read_data_b[d], rsp_addr_lo[d], rsp_byte_access[d]};
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL %s d%0d got %h want 0", tag, d, obs);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            mem_req[d] = 1'b1; mem_write[d] = 1'b0; alu_result[d] = 32'h44; byte_access[d] = ACC_WORD;
        end
        #1;
        for (int d = 0; d < 3; d++) check_all_zero(d, "reset_held");
        @(negedge clk);
        for (int d = 0; d < 3; d++) mem_req[d] = 1'b0;
        reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check_all_zero(d, "reset_release");
    endtask

    task automatic test_prefill();
        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 256; w++) run_access(d, 1'b1, ACC_WORD, 32'(w * 4), $urandom);
            idle();
        end
    endtask

    task automatic test_directed();
        run_access(0, 1'b1, ACC_BYTE, 32'h103, 32'hAB);
        n_cmp++;
        if ({bram_addr[0], bram_we[0], bram_wdata[0], stall[0]} !== {10'h40, 4'b1000, 32'hABABABAB, 1'b0}) begin
            n_err++;
            $display("FAIL sb_0x103 got %h/%b/%h/%b want 040/1000/abababab/0",
                     bram_addr[0], bram_we[0], bram_wdata[0], stall[0]);
        end
        run_access(0, 1'b1, ACC_HALF, 32'h102, 32'h1234);
        n_cmp++;
        if ({bram_we[0], bram_wdata[0]} !== {4'b1100, 32'h12341234}) begin
            n_err++;
            $display("FAIL sh_0x102 got %b/%h want 1100/12341234", bram_we[0], bram_wdata[0]);
        end
        run_access(0, 1'b0, ACC_WORD, 32'h100, 32'h0);
        n_cmp++;
        if ({rsp_valid[0], read_data_b[0][31:16]} !== {1'b1, 16'h1234}) begin
            n_err++;
            $display("FAIL lw_0x100 got %b/%h want 1/1234xxxx", rsp_valid[0], read_data_b[0]);
        end
        idle();
        run_access(1, 1'b0, ACC_BYTE, 32'h205, 32'h0);
        n_cmp++;
        if ({rsp_addr_lo[1], rsp_byte_access[1]} !== {2'b01, 3'b001}) begin
            n_err++;
            $display("FAIL lb_0x205 got %b/%b want 01/001", rsp_addr_lo[1], rsp_byte_access[1]);
        end
        idle();
    endtask

    task automatic test_misaligned();
        for (int d = 0; d < 3; d++) begin
            run_access(d, 1'b0, ACC_WORD, 32'h006, 32'h0);
            idle();
            run_access(d, 1'b0, ACC_HALF, 32'h003, 32'h0);
            idle();
            run_access(d, 1'b1, ACC_WORD, 32'h00A, 32'hDEADBEEF);
            idle();
        end
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        mem_req[2] = 1'b1; mem_write[2] = 1'b0; alu_result[2] = 32'h40; byte_access[2] = ACC_WORD;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero(2, "reset_mid_wait");
        @(negedge clk);
        mem_req[2] = 1'b0;
        reset = 1'b0;
        for (int d = 0; d < 3; d++) last_load[d] = '0;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++;
            if ({rsp_valid[2], stall[2], read_data_b[2]} !== 34'h0) begin
                n_err++;
                $display("FAIL reset_drop cyc%0d got %b/%b/%h want 0/0/0", k, rsp_valid[2], stall[2], read_data_b[2]);
            end
            @(negedge clk);
        end
        run_access(2, 1'b0, ACC_WORD, 32'h40, 32'h0);
        idle();
    endtask

    task automatic test_back_to_back();
        run_access(0, 1'b1, ACC_WORD, 32'h10, $urandom);
        run_access(0, 1'b1, ACC_WORD, 32'h14, $urandom);
        run_access(0, 1'b0, ACC_WORD, 32'h10, 32'h0);
        run_access(0, 1'b0, ACC_WORD, 32'h14, 32'h0);
        idle();
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 150; n++) begin
                addr = ($urandom & 32'hFFFF_F000) | $urandom_range(0, 1023);
                run_access(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), addr, $urandom);
                if ($urandom_range(0, 3) == 0) idle();
            end
            idle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            mem_req[d] = 1'b0; mem_write[d] = 1'b0; alu_result[d] = '0;
            write_data[d] = '0; byte_access[d] = '0; last_load[d] = '0;
        end
        test_reset();
        test_prefill();
        test_directed();
        test_misaligned();
        test_reset_mid_load();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage controller between the pipeline's M stage and the data BRAM. It turns load/store requests into BRAM port signals: word address, per-byte write enables and lane-replicated write data. It stalls the pipeline for the BRAM read latency and hands the raw 32-bit read word, plus the latched byte offset and access size, to the load byte-extraction stage. It also flags misaligned accesses and suppresses them.

## Interface
Parameters:
- ADDR_W, 10, BRAM word-address width (4 KiB at default)
- RD_LAT, 1, BRAM read latency in cycles (1 = unregistered output, 2 = output register); legal range 1..4

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- MemReq  in  1  M-stage instruction is a load or store
- MemWrite  in  1  1 = store, 0 = load (qualified by MemReq)
- ALUResult  in  32  byte address
- WriteData  in  32  store data, right-aligned
- ByteAccess  in  3  00 word, 01 byte, 10 half; 11 treated as word
- Stall  out  1  freeze F/D/E/M stages
- Misaligned  out  1  one-cycle pulse, access suppressed
- Bram_en  out  1  BRAM port enable
- Bram_we  out  4  byte write enables, bit i = byte lane i
- Bram_addr  out  ADDR_W  ALUResult[ADDR_W+1:2]
- Bram_wdata  out  32  lane-replicated store data
- Bram_rdata  in  32  BRAM read word
- RspValid  out  1  ReadData_b valid this cycle
- ReadData_b  out  32  raw read word for byte extraction
- RspAddrLo  out  2  ALUResult[1:0] latched at load acceptance
- RspByteAccess  out  3  ByteAccess latched at load acceptance

## Operation
- FSM states: IDLE, WAIT, DONE. Reset puts the FSM in IDLE and sets all outputs to 0, including ReadData_b, RspAddrLo and RspByteAccess.
- Misalignment is evaluated only in IDLE with MemReq=1:
  - half access with ALUResult[0]=1 is misaligned
  - word access with ALUResult[1:0]≠00 is misaligned
  - on misalignment: Misaligned=1, Bram_en=0, Bram_we=0, Stall=0; FSM stays in IDLE
- Store in IDLE, aligned: single cycle, Bram_en=1, Stall=0, FSM stays in IDLE. Lane rules by access size:
  - byte: we = 0001<<ALUResult[1:0]; wdata = {4{WriteData[7:0]}}
  - half: we = ALUResult[1] ? 1100 : 0011; wdata = {2{WriteData[15:0]}}
  - word: we = 1111; wdata = WriteData
- Load in IDLE, aligned:
  - Bram_en=1, Bram_we=0, Stall=1
  - latch RspAddrLo and RspByteAccess
  - next state is WAIT if RD_LAT>1, else DONE
- WAIT: Stall=1 and the counter increments. FSM moves to DONE after RD_LAT-1 WAIT cycles in total. Bram_en and Bram_addr are held at the accepted address.
- DONE:
  - Stall=0, RspValid=1, ReadData_b = Bram_rdata (pass-through), and the same value is captured into the hold register
  - inputs are ignored, because this is the cycle in which the same instruction leaves M
  - next state is IDLE
- Outside DONE, ReadData_b shows the hold register (last loaded word).
- When MemReq=0 in IDLE, Bram_en=0, Bram_we=0 and there is no state change.

## Timing
- Store: zero stall, written at the end of the acceptance cycle.
- Load accepted in cycle T: Stall is high in T..T+RD_LAT-1. RspValid and the data appear in T+RD_LAT. Occupancy is RD_LAT+1 cycles.
- Back-to-back loads: the second load is accepted in the IDLE cycle after DONE. Minimum spacing is RD_LAT+1 cycles.
- Reset asserted mid-load: the FSM returns to IDLE immediately. No RspValid is produced, and the pending read is dropped.
- ALUResult bits above ADDR_W+1 are ignored, so addresses wrap modulo the BRAM size.

## Structure
- Shared package dmem_pkg holds:
  - the ByteAccess encodings: ACC_WORD, ACC_BYTE, ACC_HALF
  - the FSM state enum: dmem_state_t
- Sub-module store_lane_align (combinational) computes Bram_we and Bram_wdata from the offset, access size and WriteData. The FSM, counter and latches stay in dmem_access_ctrl.

## Test plan
- sb, ALUResult=0x103, WriteData=0xAB -> Bram_addr=0x40, we=1000, wdata=0xABABABAB, Stall=0.
- sh, ALUResult=0x102, WriteData=0x1234 -> we=1100, wdata=0x12341234. Then lw at 0x100, with the BRAM model returning the stored word -> ReadData_b=0x1234xxxx in DONE.
- lb, ALUResult=0x205, RD_LAT=2 -> Stall high exactly 2 cycles, RspValid in the third cycle, RspAddrLo=01, RspByteAccess=01.
- lw, ALUResult=0x006 -> Misaligned pulses one cycle, Bram_en=0, Stall=0, FSM stays in IDLE. Same for lh at 0x003.
- reset asserted during WAIT (RD_LAT=3) -> Stall drops immediately, no RspValid, all outputs 0. The next load behaves normally.
- two back-to-back lw (0x10 then 0x14, RD_LAT=1) -> two RspValid pulses 2 cycles apart, each carrying its own word; no duplicate BRAM read in a DONE cycle.
